// File: rtl/pr_req_arbiter_if.sv
// Request/response and value-table bundle between the PageRank engines and
// the shared remote-read arbiter.
interface pr_req_arbiter_if #(
  parameter int NUM_ENG = 4,
  parameter int WIDTH   = 16,
  parameter int OFFW    = 4
);
  logic [NUM_ENG*(5+OFFW)-1:0]     req_pkt;
  logic [NUM_ENG*(WIDTH+OFFW+1)-1:0] resp_pkt;
  logic                            rd_en;
  logic [1:0]                      rd_eng;
  logic [OFFW-1:0]                 rd_addr;
  logic [WIDTH-1:0]                rd_data;
  logic                            busy;
  logic [15:0]                     served_cnt;
  logic [7:0]                      err_cnt;

  // Arbiter side
  modport slave (
    input  req_pkt, rd_data,
    output resp_pkt, rd_en, rd_eng, rd_addr, busy, served_cnt, err_cnt
  );

  // Engine / value-table side
  modport master (
    output req_pkt, rd_data,
    input  resp_pkt, rd_en, rd_eng, rd_addr, busy, served_cnt, err_cnt
  );
endinterface

// File: rtl/pr_req_arbiter.sv
// Round-robin remote-read arbiter: grants one engine request at a time, reads
// the owning engine's value table and returns a response packet to the
// requester. Malformed requests (bad or self destination) get an error reply.
module pr_req_arbiter #(
  parameter int NUM_ENG = 4,
  parameter int WIDTH   = 16,
  parameter int OFFW    = 4
) (
  input  logic            clk,
  input  logic            reset,
  pr_req_arbiter_if.slave bus_io
);
  localparam int RW = 5 + OFFW;         // request lane width
  localparam int PW = WIDTH + OFFW + 1; // response lane width

  typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           g_q, g_d;
  logic [OFFW-1:0]      off_q, off_d;
  logic [NUM_ENG-1:0]   cool_q, cool_d;
  logic [NUM_ENG*PW-1:0] resp_q, resp_d;
  logic                 rd_en_q, rd_en_d;
  logic [1:0]           rd_eng_q, rd_eng_d;
  logic [OFFW-1:0]      rd_addr_q, rd_addr_d;
  logic                 busy_q, busy_d;
  logic [15:0]          served_q, served_d;
  logic [7:0]           err_q, err_d;

  logic [NUM_ENG-1:0]   req_v, elig;
  logic [1:0]           req_dst [NUM_ENG];
  logic [OFFW-1:0]      req_off [NUM_ENG];
  logic [2*NUM_ENG-1:0] unused_src;

  logic                 found, bad;
  logic [1:0]           gsel, cand;

  // Unpack request lanes; the src field carries no routing information.
  for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_lane
    assign req_v[gi]            = bus_io.req_pkt[gi*RW];
    assign req_dst[gi]          = bus_io.req_pkt[gi*RW+1 +: 2];
    assign unused_src[gi*2 +: 2] = bus_io.req_pkt[gi*RW+3 +: 2];
    assign req_off[gi]          = bus_io.req_pkt[gi*RW+5 +: OFFW];
    assign elig[gi]             = req_v[gi] & ~cool_q[gi];
  end

  // Round-robin search: first eligible engine starting after the last grant.
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      cand = 2'((int'(ptr_q) + 1 + i) % NUM_ENG);
      if (!found && elig[cand]) begin
        found = 1'b1;
        gsel  = cand;
      end
    end
  end

  // A request cannot target a missing engine or the requester itself.
  assign bad = (int'(req_dst[gsel]) >= NUM_ENG) || (req_dst[gsel] == gsel);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = bad ? RESP : READ;
      READ:    state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the grant context.
  always_comb begin
    ptr_d     = ptr_q;
    g_d       = g_q;
    off_d     = off_q;
    cool_d    = '0;
    resp_d    = '0;
    rd_en_d   = 1'b0;
    rd_eng_d  = rd_eng_q;
    rd_addr_d = rd_addr_q;
    served_d  = served_q;
    err_d     = err_q;
    busy_d    = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (found) begin
          ptr_d = gsel;
          g_d   = gsel;
          off_d = req_off[gsel];
          if (bad) begin
            resp_d[int'(gsel)*PW +: PW] = {{WIDTH{1'b0}}, req_off[gsel], 1'b1};
            err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          end else begin
            rd_en_d   = 1'b1;
            rd_eng_d  = req_dst[gsel];
            rd_addr_d = req_off[gsel];
          end
        end
      end
      WAIT: begin
        resp_d[int'(g_q)*PW +: PW] = {bus_io.rd_data, off_q, 1'b1};
        served_d = (served_q == 16'hFFFF) ? served_q : served_q + 16'd1;
      end
      RESP:    cool_d[g_q] = 1'b1;
      default: ;
    endcase
  end

  // Output and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= 2'(NUM_ENG - 1);
      g_q       <= '0;
      off_q     <= '0;
      cool_q    <= '0;
      resp_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_eng_q  <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      served_q  <= '0;
      err_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      off_q     <= off_d;
      cool_q    <= cool_d;
      resp_q    <= resp_d;
      rd_en_q   <= rd_en_d;
      rd_eng_q  <= rd_eng_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      served_q  <= served_d;
      err_q     <= err_d;
    end
  end

  assign bus_io.resp_pkt   = resp_q;
  assign bus_io.rd_en      = rd_en_q;
  assign bus_io.rd_eng     = rd_eng_q;
  assign bus_io.rd_addr    = rd_addr_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.served_cnt = served_q;
  assign bus_io.err_cnt    = err_q;
endmodule

// File: tb/tb_pr_req_arbiter.sv
// Scoreboard bench for pr_req_arbiter: expected reads and responses are queued
// when requests are driven and compared as the arbiter produces them.
module tb_pr_req_arbiter;
  localparam int NUM_ENG = 4;
  localparam int WIDTH   = 16;
  localparam int OFFW    = 4;
  localparam int RW      = 5 + OFFW;
  localparam int PW      = WIDTH + OFFW + 1;

  typedef struct {int eng; logic [PW-1:0] pkt; int cyc;} resp_t;
  typedef struct {int eng; int addr; int cyc;} rd_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_served = 0;
  int   exp_err = 0;
  int   reload [NUM_ENG];
  int   served_by [NUM_ENG];
  logic [WIDTH-1:0] mem [NUM_ENG][16];
  resp_t sb [$];
  rd_t   rd_q [$];

  pr_req_arbiter_if #(.NUM_ENG(NUM_ENG), .WIDTH(WIDTH), .OFFW(OFFW)) bus ();

  pr_req_arbiter #(.NUM_ENG(NUM_ENG), .WIDTH(WIDTH), .OFFW(OFFW)) dut (
    .clk    (clk),
    .reset  (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Value tables: data appears the cycle after the read strobe.
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_eng][bus.rd_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [3:0] off_seq(input int e, input int j);
    return 4'((3 * j + 5 * e + 1) % 16);
  endfunction

  task automatic req(input int e, input int dst, input int off);
    bus.req_pkt[e*RW +: RW] = {4'(off), 2'(3 - e), 2'(dst), 1'b1};
  endtask

  task automatic expect_good(input int e, input int dst, input int off, input int t);
    rd_q.push_back(rd_t'{eng: dst, addr: off, cyc: t - 2});
    sb.push_back(resp_t'{eng: e, pkt: {mem[dst][off], 4'(off), 1'b1}, cyc: t});
    exp_served = (exp_served == 65535) ? 65535 : exp_served + 1;
  endtask

  task automatic expect_err(input int e, input int off, input int t);
    sb.push_back(resp_t'{eng: e, pkt: {16'h0000, 4'(off), 1'b1}, cyc: t});
    exp_err = (exp_err == 255) ? 255 : exp_err + 1;
  endtask

  // One clock: sample on the falling edge, score reads/responses, and let
  // each engine either re-request with a new offset or drop its request.
  task automatic step();
    logic [PW-1:0] lane;
    rd_t   r;
    resp_t x;
    @(negedge clk);
    if (bus.rd_en === 1'b1) begin
      check("rd_expected", 64'(rd_q.size() > 0), 64'd1);
      if (rd_q.size() > 0) begin
        r = rd_q.pop_front();
        check("rd_eng", 64'(bus.rd_eng), 64'(r.eng));
        check("rd_addr", 64'(bus.rd_addr), 64'(r.addr));
        check("rd_cycle", 64'(cyc), 64'(r.cyc));
      end
    end
    for (int e = 0; e < NUM_ENG; e++) begin
      lane = bus.resp_pkt[e*PW +: PW];
      if (lane[0] === 1'b1) begin
        $display("resp eng=%0d value=%h off=%0d cycle=%0d", e, lane[PW-1:5], lane[4:1], cyc);
        check("resp_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          x = sb.pop_front();
          check("resp_eng", 64'(e), 64'(x.eng));
          check("resp_pkt", 64'(lane), 64'(x.pkt));
          check("resp_cycle", 64'(cyc), 64'(x.cyc));
        end
        served_by[e]++;
        if (reload[e] > 0) begin
          reload[e]--;
          bus.req_pkt[e*RW+5 +: 4] = off_seq(e, served_by[e]);
        end else begin
          bus.req_pkt[e*RW] = 1'b0;
        end
      end
    end
  endtask

  task automatic drained(input string tag);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({tag, "_rd_empty"}, 64'(rd_q.size()), 64'd0);
    check({tag, "_served"}, 64'(bus.served_cnt), 64'(exp_served));
    check({tag, "_err"}, 64'(bus.err_cnt), 64'(exp_err));
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_resp"}, 64'(|bus.resp_pkt), 64'd0);
    check({tag, "_rd_en"}, 64'(bus.rd_en), 64'd0);
    check({tag, "_rd_eng"}, 64'(bus.rd_eng), 64'd0);
    check({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_served"}, 64'(bus.served_cnt), 64'd0);
    check({tag, "_err"}, 64'(bus.err_cnt), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_pkt = '0;
    sb.delete();
    rd_q.delete();
    for (int e = 0; e < NUM_ENG; e++) reload[e] = 0;
    repeat (2) step();
    rst = 1'b0;
    exp_served = 0;
    exp_err = 0;
  endtask

  initial begin
    int c, base0, base1, base3;
    rst = 1'b1;
    bus.req_pkt = '0;
    for (int e = 0; e < NUM_ENG; e++) begin
      reload[e] = 0;
      served_by[e] = 0;
      for (int o = 0; o < 16; o++) mem[e][o] = 16'(e * 16'h1000 + o * 16'h0111 + 16'h0A0B);
    end
    mem[2][5] = 16'h1234;

    // Reset state
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Single good read: eng0 -> table 2, offset 5
    c = cyc;
    req(0, 2, 5);
    expect_good(0, 2, 5, c + 3);
    step();
    check("t1_busy_in_read", 64'(bus.busy), 64'd1);
    repeat (5) step();
    drained("t1");

    // All four at once after reset: grant order 0,1,2,3 every 4 cycles
    do_reset();
    c = cyc;
    for (int e = 0; e < NUM_ENG; e++) begin
      req(e, (e + 1) % NUM_ENG, 4 + e);
      expect_good(e, (e + 1) % NUM_ENG, 4 + e, c + 3 + 4 * e);
    end
    repeat (18) step();
    drained("t2");

    // Two engines re-requesting continuously alternate without duplicates
    base0 = served_by[0];
    base1 = served_by[1];
    reload[0] = 3;
    reload[1] = 3;
    c = cyc;
    req(0, 2, int'(off_seq(0, base0)));
    req(1, 3, int'(off_seq(1, base1)));
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) expect_good(0, 2, int'(off_seq(0, base0 + k / 2)), c + 3 + 4 * k);
      else            expect_good(1, 3, int'(off_seq(1, base1 + k / 2)), c + 3 + 4 * k);
    end
    repeat (36) step();
    drained("t3");

    // Self-destination request: error reply one cycle later, no table read
    c = cyc;
    req(3, 3, 9);
    expect_err(3, 9, c + 1);
    repeat (4) step();
    drained("t4");

    // Reset during WAIT aborts the read; held request is served afterwards
    c = cyc;
    req(1, 0, 7);
    expect_good(1, 0, 7, c + 3);
    step();
    step();
    check("t5_busy_in_wait", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check_all_zero("t5_async");
    sb.delete();
    rd_q.delete();
    exp_served = 0;
    exp_err = 0;
    repeat (2) step();
    rst = 1'b0;
    c = cyc;
    expect_good(1, 0, 7, c + 3);
    repeat (6) step();
    drained("t5");

    // served_cnt saturation: preload near the top, then real responses
    force dut.served_q = 16'hFFFD;
    step();
    release dut.served_q;
    exp_served = 65533;
    for (int i = 0; i < 4; i++) begin
      c = cyc;
      req(2, 0, i);
      expect_good(2, 0, i, c + 3);
      repeat (5) step();
      check("t6_served_sat", 64'(bus.served_cnt), 64'(exp_served));
    end
    drained("t6a");

    // err_cnt saturation with a continuously held bad request (3-cycle cadence)
    base3 = served_by[3];
    reload[3] = 259;
    c = cyc;
    req(3, 3, int'(off_seq(3, base3)));
    for (int k = 0; k < 260; k++) expect_err(3, int'(off_seq(3, base3 + k)), c + 1 + 3 * k);
    repeat (260 * 3 + 3) step();
    drained("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
